// File: rtl/alsu_bist_sequencer.sv
// Exhaustive self-test sequencer for the bypass/equality/SLT unit: sweeps every {Sel,A,B}.
// Optional BIST_STOP_ON_FAIL_EN: stop the sweep at the first mismatching vector.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | after reset, waiting for start
// S_DRIVE | present vec on the drive registers, arm the settle timer
// S_WAIT  | let the unit settle for SETTLE cycles
// S_CHECK | compare dut_out with the golden result, advance or finish
// S_DONE  | results valid; start begins a new sweep
module alsu_bist_sequencer #(
  parameter int WIDTH  = 4,
  parameter int SEL_W  = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 11
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [WIDTH-1:0]         a_drv,
  output logic [WIDTH-1:0]         b_drv,
  output logic [SEL_W-1:0]         sel_drv,
  input  logic [WIDTH-1:0]         dut_out,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [ERR_W-1:0]         error_count,
  output logic [SEL_W+2*WIDTH-1:0] fail_vec
);

  localparam int VEC_W  = SEL_W + 2*WIDTH;
  localparam int WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic [VEC_W-1:0]    vec;
  logic [WAIT_W-1:0]   wait_cnt;
  logic                first_fail;
  logic [WIDTH-1:0]    expected;
  logic                mismatch;
  logic                last_vec;

  // Golden result is derived from what was actually driven, not from vec.
  always_comb begin
    expected = '0;
    case (sel_drv)
      SEL_W'(0): expected    = a_drv;
      SEL_W'(1): expected    = b_drv;
      SEL_W'(2): expected[0] = (a_drv == b_drv);
      SEL_W'(3): expected[0] = (a_drv < b_drv);
      default:   expected    = '0;
    endcase
  end

  assign mismatch = (dut_out != expected);
  assign last_vec = &vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    pass      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_DRIVE;
      end
      S_DRIVE: begin
        busy      = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (wait_cnt == '0) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        busy = 1'b1;
`ifdef BIST_STOP_ON_FAIL_EN
        state_nxt = (last_vec || mismatch) ? S_DONE : S_DRIVE;
`else
        state_nxt = last_vec ? S_DONE : S_DRIVE;
`endif
      end
      S_DONE: begin
        done = 1'b1;
        pass = (error_count == '0);
        if (start) state_nxt = S_DRIVE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec         <= '0;
      wait_cnt    <= '0;
      first_fail  <= 1'b0;
      error_count <= '0;
      fail_vec    <= '0;
      a_drv       <= '0;
      b_drv       <= '0;
      sel_drv     <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            vec         <= '0;
            first_fail  <= 1'b0;
            error_count <= '0;
            fail_vec    <= '0;
          end
        end
        S_DRIVE: begin
          {sel_drv, a_drv, b_drv} <= vec;
          wait_cnt                <= WAIT_W'(SETTLE - 1);
        end
        S_WAIT: begin
          if (wait_cnt != '0) wait_cnt <= wait_cnt - WAIT_W'(1);
        end
        S_CHECK: begin
          if (mismatch) begin
            if (~&error_count) error_count <= error_count + ERR_W'(1);
            if (!first_fail) begin
              fail_vec   <= {sel_drv, a_drv, b_drv};
              first_fail <= 1'b1;
            end
          end
`ifdef BIST_STOP_ON_FAIL_EN
          if (!last_vec && !mismatch) vec <= vec + VEC_W'(1);
`else
          if (!last_vec) vec <= vec + VEC_W'(1);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_bist_sequencer.sv
// Scoreboard bench: two sequencers (SETTLE=1 and SETTLE=3) drive a pipelined unit model with injectable faults.
module tb_alsu_bist_sequencer;

  localparam int NI  = 2;
  localparam int ST0 = 1;
  localparam int ST1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  a_drv [NI];
  logic [3:0]  b_drv [NI];
  logic [1:0]  sel_drv [NI];
  logic [3:0]  dut_out [NI];
  logic        busy [NI];
  logic        done [NI];
  logic        pass [NI];
  logic [10:0] error_count [NI];
  logic [9:0]  fail_vec [NI];

  int checks = 0;
  int failures = 0;
  int excl_viol = 0;

  // fault_kind: 0 none, 1 stuck-at-0, 2 stuck-at-1, 3 bit flip when (A^B)==fault_key
  int         fault_kind = 0;
  logic [1:0] fault_bit = 2'd0;
  logic [3:0] fault_key = 4'd0;

  typedef struct {
    int         len;
    int         errs;
    logic [9:0] fvec;
    logic [9:0] last;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  function automatic logic [3:0] spec_out(logic [1:0] s, logic [3:0] a, logic [3:0] b);
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return (a == b) ? 4'd1 : 4'd0;
      default: return (a < b) ? 4'd1 : 4'd0;
    endcase
  endfunction

  function automatic logic [3:0] unit_out(logic [1:0] s, logic [3:0] a, logic [3:0] b);
    logic [3:0] r;
    r = spec_out(s, a, b);
    case (fault_kind)
      1: r[fault_bit] = 1'b0;
      2: r[fault_bit] = 1'b1;
      3: if ((a ^ b) == fault_key) r[fault_bit] = ~r[fault_bit];
      default: ;
    endcase
    return r;
  endfunction

  function automatic exp_t model(int st);
    exp_t e;
    logic [9:0] vv;
    e.errs = 0;
    e.fvec = '0;
    e.last = 10'h3FF;
    e.len  = 1024 * (2 + st);
    for (int v = 0; v < 1024; v++) begin
      vv = 10'(v);
      if (unit_out(vv[9:8], vv[7:4], vv[3:0]) != spec_out(vv[9:8], vv[7:4], vv[3:0])) begin
        if (e.errs == 0) e.fvec = vv;
        e.errs++;
`ifdef BIST_STOP_ON_FAIL_EN
        e.last = vv;
        e.len  = (v + 1) * (2 + st);
        break;
`endif
      end
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int outs_nonzero(int g);
    int n;
    n = 0;
    if (a_drv[g] != 0)       n++;
    if (b_drv[g] != 0)       n++;
    if (sel_drv[g] != 0)     n++;
    if (busy[g])             n++;
    if (done[g])             n++;
    if (pass[g])             n++;
    if (error_count[g] != 0) n++;
    if (fail_vec[g] != 0)    n++;
    return n;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int ST = (g == 0) ? ST0 : ST1;
    logic [3:0] pipe [ST];
    int         busy_cyc = 0;
    logic       prev_done = 1'b0;
    exp_t       e;

    alsu_bist_sequencer #(.WIDTH(4), .SEL_W(2), .SETTLE(ST), .ERR_W(11)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .a_drv       (a_drv[g]),
      .b_drv       (b_drv[g]),
      .sel_drv     (sel_drv[g]),
      .dut_out     (dut_out[g]),
      .busy        (busy[g]),
      .done        (done[g]),
      .pass        (pass[g]),
      .error_count (error_count[g]),
      .fail_vec    (fail_vec[g])
    );

    // Unit result only becomes valid ST cycles after the drive changes.
    always @(posedge clk) begin
      pipe[0] <= unit_out(sel_drv[g], a_drv[g], b_drv[g]);
      for (int i = 1; i < ST; i++) pipe[i] <= pipe[i-1];
    end
    assign dut_out[g] = pipe[ST-1];

    always @(negedge clk) begin
      if (!rst_n) begin
        busy_cyc  = 0;
        prev_done = 1'b0;
      end else begin
        if (busy[g] && done[g]) excl_viol++;
        if (busy[g]) busy_cyc++;
        if (prev_done && !done[g] && busy[g])
          chk($sformatf("u%0d_restart_clear", g), int'(error_count[g]), 0);
        if (done[g] && !prev_done) begin
          if ((g == 0 && q0.size() == 0) || (g == 1 && q1.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL u%0d_unexpected_done actual=done required=no_pending_sweep", g);
          end else begin
            if (g == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk($sformatf("u%0d_len", g), busy_cyc, e.len);
            chk($sformatf("u%0d_errs", g), int'(error_count[g]), e.errs);
            chk($sformatf("u%0d_pass", g), int'(pass[g]), (e.errs == 0) ? 1 : 0);
            chk($sformatf("u%0d_fail_vec", g), int'(fail_vec[g]), int'(e.fvec));
            chk($sformatf("u%0d_last_drive", g), int'({sel_drv[g], a_drv[g], b_drv[g]}), int'(e.last));
          end
          busy_cyc = 0;
        end
        prev_done = done[g];
      end
    end
  end

  task automatic push_both(input int n);
    for (int i = 0; i < n; i++) begin
      q0.push_back(model(ST0));
      q1.push_back(model(ST1));
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int c;
    c = 0;
    while (!(done[0] && done[1]) && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (!(done[0] && done[1])) begin
      failures++;
      $display("FAIL %s_timeout actual=not_done required=done_within_%0d", name, budget);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int g = 0; g < NI; g++) chk($sformatf("u%0d_reset_outputs", g), outs_nonzero(g), 0);
    rst_n = 1'b1;
    @(negedge clk);

    fault_kind = 0;
    push_both(1);
    pulse_start();
    wait_done("clean", 12000);

    fault_kind = 1;
    fault_bit  = 2'd0;
    push_both(1);
    pulse_start();
    wait_done("stuck0", 12000);

    fault_kind = 0;
    push_both(1);
    pulse_start();
    repeat (500) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < NI; g++) chk($sformatf("u%0d_async_reset", g), outs_nonzero(g), 0);
    q0.delete();
    q1.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    push_both(1);
    pulse_start();
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("start_while_busy", 12000);

    fault_kind = 1;
    fault_bit  = 2'($urandom_range(0, 3));
    push_both(2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 12000 && !done[1]; c++) @(negedge clk);
    chk("held_first_done", int'(done[1]), 1);
    @(negedge clk);
    start = 1'b0;
    wait_done("held_restart", 12000);

    for (int r = 0; r < 3; r++) begin
      fault_kind = $urandom_range(0, 3);
      fault_bit  = 2'($urandom_range(0, 3));
      fault_key  = 4'($urandom_range(0, 15));
      push_both(1);
      pulse_start();
      wait_done($sformatf("random%0d", r), 12000);
    end

    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("busy_done_exclusive", excl_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
